// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES-128 key schedule blocks.
//  - AES128_ROUNDS / AES128_LAST_RCON : round count and the rcon of the last round
//  - key_state_e                      : key schedule FSM encoding
//  - inv_xtime(b)                     : multiply a GF(2^8) byte by x^-1
//  - rotword(w)                       : cyclic byte rotate left of a 32-bit word
package aes_key_pkg;

  localparam int           AES128_ROUNDS    = 10;
  localparam logic [7:0]   AES128_LAST_RCON = 8'h36;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } key_state_e;

  // x^-1 modulo x^8+x^4+x^3+x+1: shift right and, when bit 0 falls out,
  // fold back (poly >> 1) with the top bit set, i.e. 8'h8d.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? ({1'b0, b[7:1]} ^ 8'h8d) : {1'b0, b[7:1]};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box applied to each byte of a 32-bit word (SubWord).
// Ports:
//   word_i  in  32  input word
//   word_o  out 32  byte-wise S-box substitution of word_i (combinational)
module aes_sbox (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Entry 0 sits in the top byte, so entry b lives at bit (255-b)*8.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  always_comb begin
    word_o = {sb(word_i[31:24]), sb(word_i[23:16]), sb(word_i[15:8]), sb(word_i[7:0])};
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse-direction AES-128 key schedule. Loaded with the last round key, it
// derives the previous round key one step at a time down to the cipher key.
// Optional feature macro: AES_INV_KEY_AUTO_EN (free-running walk after init).
// Ports:
//   clk        in   1    clock, all state on posedge
//   reset_n    in   1    synchronous active-low reset (dominates init)
//   init       in   1    strobe: load last_key, round=NUM_ROUNDS, rcon=LAST_RCON
//   next       in   1    strobe: step to the previous round key
//   last_key   in   128  round-NUM_ROUNDS key, word0 in [127:96]
//   round_key  out  128  current round key (registered)
//   round      out  4    index of round_key
//   rcon       out  8    rcon belonging to the current round
//   valid      out  1    round_key holds a loaded/derived key
//   done       out  1    valid and round==0
//   dbg_state  out  2    FSM state (key_state_e encoding)
// Handshake: init and next are single-cycle strobes with no back-pressure.
// A strobe sampled high on a rising edge takes effect on that edge; init has
// priority over next, and next outside ACTIVE is dropped.
module aes_inv_key_sched
  import aes_key_pkg::*;
#(
  parameter int         NUM_ROUNDS = AES128_ROUNDS,
  parameter logic [7:0] LAST_RCON  = AES128_LAST_RCON
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [127:0] last_key,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic [7:0]   rcon,
  output logic         valid,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam logic [3:0] LAST_ROUND = NUM_ROUNDS[3:0];

  key_state_e   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         load, step, step_req;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_out;

`ifdef AES_INV_KEY_AUTO_EN
  // Walk runs on its own once loaded; next has no meaning here.
  assign step_req = 1'b1;
  logic unused_next;
  assign unused_next = next;
`else
  assign step_req = next;
`endif

  // FSM: next state plus the load/step enables for the datapath.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    if (init) begin
      load    = 1'b1;
      state_d = ST_ACTIVE;
    end else if (state_q == ST_ACTIVE && step_req) begin
      step = 1'b1;
      if (round_q == 4'd1) state_d = ST_DONE;
    end
  end

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Undo the forward recurrence: the previous w3 is recovered first, and it
  // is the word the forward schedule pushed through SubWord(RotWord()).
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sbox u_sbox (
    .word_i (rotword(p3)),
    .word_o (sub_out)
  );

  assign p0 = w0 ^ sub_out ^ {rcon_q, 24'h0};

  // Next key / round / rcon.
  always_comb begin
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    if (load) begin
      key_d   = last_key;
      round_d = LAST_ROUND;
      rcon_d  = LAST_RCON;
    end else if (step) begin
      key_d   = {p0, p1, p2, p3};
      round_d = round_q - 4'd1;
      rcon_d  = inv_xtime(rcon_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign round_key = key_q;
  assign round     = round_q;
  assign rcon      = rcon_q;
  assign valid     = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Testbench for aes_inv_key_sched. Reference model: forward AES-128 key
// expansion of a cipher key (S-box derived from GF(2^8) inversion plus the
// affine map), then the DUT is expected to present those round keys in
// reverse order. Expected outputs are queued by the driver each cycle and
// popped by an independent monitor.
module tb_aes_inv_key_sched;

`ifdef AES_INV_KEY_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic         init;
  logic         next;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic         valid;
  logic         done;
  logic [1:0]   dbg_state;

  aes_inv_key_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .next      (next),
    .last_key  (last_key),
    .round_key (round_key),
    .round     (round),
    .rcon      (rcon),
    .valid     (valid),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / check ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [7:0]   rc_m   [11];
  logic [127:0] t_rk   [11];   // freshly expanded schedule
  logic [127:0] m_rk   [11];   // schedule currently loaded in the model
  logic         m_valid;
  int           m_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_m[0] = 8'h8d;
    rc_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc_m[i] = xtime(rc_m[i-1]);
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) t_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [141:0] model_out();
    if (!m_valid) return '0;
    return {1'b1, (m_round == 0), 4'(m_round), rc_m[m_round], m_rk[m_round]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [141:0] exp_q [$];

  // Driver: one call = one clock cycle of stimulus, with its expected result queued.
  task automatic drive(input logic rst_v, input logic init_v, input logic next_v,
                       input logic [127:0] key_v);
    @(negedge clk);
    reset_n  = rst_v;
    init     = init_v;
    next     = next_v;
    last_key = key_v;
    if (!rst_v) begin
      m_valid = 1'b0;
      m_round = 0;
    end else if (init_v) begin
      m_valid = 1'b1;
      m_round = 10;
      for (int r = 0; r <= 10; r++) m_rk[r] = t_rk[r];
    end else if (m_valid && m_round > 0 && (next_v || AUTO)) begin
      m_round = m_round - 1;
    end
    exp_q.push_back(model_out());
  endtask

  // Settle to just after the edge that consumed the last driven cycle.
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitor
  initial begin
    logic [141:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_outputs", {valid, done, round, rcon, round_key}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] CIPHER_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  initial begin
    logic [127:0] rk_k0;
    logic [127:0] rnd_key;
    reset_n  = 1'b0;
    init     = 1'b0;
    next     = 1'b0;
    last_key = '0;
    m_valid  = 1'b0;
    m_round  = 0;
    build_tables();
    for (int r = 0; r <= 10; r++) m_rk[r] = '0;

    // Reset held for two cycles, with next toggling to show it is ignored.
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    settle();
    chk("reset_state", {valid, done, round, rcon, round_key}, '0);

    // Known vector: init with the round-10 key of the FIPS-197 example.
    expand(CIPHER_KEY);
    rk_k0 = t_rk[10];
    drive(1'b1, 1'b1, 1'b0, rk_k0);
    settle();
    chk("init_key", {14'h0, round_key}, {14'h0, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6});
    chk("init_round_rcon", {130'h0, round, rcon}, {130'h0, 4'd10, 8'h36});

    drive(1'b1, 1'b0, 1'b1, rk_k0);
    settle();
    chk("step1_key", {14'h0, round_key}, {14'h0, 128'hac7766f3_19fadc21_28d12941_575c006e});
    chk("step1_round_rcon", {130'h0, round, rcon}, {130'h0, 4'd9, 8'h1b});

    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b1, rk_k0);
    settle();
    chk("walk_done", {valid, done, round, rcon, round_key},
        {1'b1, 1'b1, 4'd0, 8'h8d, CIPHER_KEY});

    // 11th next: nothing moves.
    drive(1'b1, 1'b0, 1'b1, rk_k0);
    settle();
    chk("extra_next_hold", {valid, done, round, rcon, round_key},
        {1'b1, 1'b1, 4'd0, 8'h8d, CIPHER_KEY});

    // init mid-walk at round 4 together with next: init wins.
    rnd_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(rnd_key);
    drive(1'b1, 1'b1, 1'b0, t_rk[10]);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, t_rk[10]);
    settle();
    chk("at_round4", {138'h0, round}, {138'h0, 4'd4});
    drive(1'b1, 1'b1, 1'b1, t_rk[10]);
    settle();
    chk("init_beats_next", {valid, done, round, rcon, round_key},
        {1'b1, 1'b0, 4'd10, 8'h36, t_rk[10]});

    // Reset at round 6; init asserted with it must lose.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, t_rk[10]);
    drive(1'b0, 1'b1, 1'b1, t_rk[10]);
    settle();
    chk("reset_midwalk", {136'h0, valid, done, round}, {136'h0, 1'b0, 1'b0, 4'd0});
    drive(1'b1, 1'b0, 1'b1, t_rk[10]);
    drive(1'b1, 1'b0, 1'b1, t_rk[10]);
    settle();
    chk("next_after_reset", {valid, done, round, rcon, round_key}, '0);

    // Single init followed by idle cycles.
    expand(CIPHER_KEY);
    drive(1'b1, 1'b1, 1'b0, rk_k0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, rk_k0);
    settle();
`ifdef AES_INV_KEY_AUTO_EN
    chk("auto_walk_final", {valid, done, round, rcon, round_key},
        {1'b1, 1'b1, 4'd0, 8'h8d, CIPHER_KEY});
`else
    chk("idle_hold_round10", {valid, done, round, rcon, round_key},
        {1'b1, 1'b0, 4'd10, 8'h36, rk_k0});
`endif

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      logic r_v, i_v, n_v;
      r_v = ($urandom_range(0, 31) != 0);
      i_v = ($urandom_range(0, 11) == 0);
      n_v = ($urandom_range(0, 1) == 1);
      if (i_v) expand({$urandom(), $urandom(), $urandom(), $urandom()});
      drive(r_v, i_v, n_v, i_v ? t_rk[10] : {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    settle();
    #10;
    chk("queue_drained", 142'(exp_q.size()), 142'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
